ids_pattern_sched: RTL

- Time-shares the single 7-byte pattern matcher across NUM_SLOTS software-loaded pattern slots.
- Round-robin scheduling: one enabled slot is assigned per packet.
- Double-buffers pattern configuration; software updates commit only at packet boundaries.
- Sequences the matcher reset, counts per-slot hits, and issues the drop decision to the drop FIFO.
- Sits between generic_regs and the matcher/drop-FIFO in the IDS user datapath stage.

---
 rtl/ids_pattern_sched.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ids_pattern_sched.sv
// Round-robin pattern-slot scheduler for the shared IDS matcher, with a double-buffered config bank.
// Optional drop output enabled by defining IDS_SCHED_DROP_EN; otherwise drop_out is tied low.
module ids_pattern_sched #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned SLOT_BITS = 2,
    parameter int unsigned PAT_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_wr,
    input  logic [SLOT_BITS-1:0]   cfg_slot,
    input  logic [PAT_WIDTH-1:0]   cfg_pattern,
    input  logic [NUM_SLOTS-1:0]   cfg_en_mask,
    input  logic                   commit_req,
    output logic                   commit_ack,
    input  logic                   clear_cnt,
    input  logic                   pkt_start,
    input  logic                   pkt_end,
    input  logic                   match_in,
    output logic [PAT_WIDTH-1:0]   pattern_out,
    output logic                   matcher_rst,
    output logic [SLOT_BITS-1:0]   active_slot,
    output logic                   drop_out,
    output logic                   in_pkt,
    output logic                   proto_err,
    output logic [32*NUM_SLOTS-1:0] hit_cnt
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IN_PKT = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    state_e                          state_q, state_d;
    logic [PAT_WIDTH-1:0]            shadow_q [NUM_SLOTS];
    logic [PAT_WIDTH-1:0]            active_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]            en_q, en_d;
    logic [PAT_WIDTH-1:0]            pattern_q, pattern_d;
    logic                            mrst_q, mrst_d;
    logic [SLOT_BITS-1:0]            slot_q;
    logic [SLOT_BITS-1:0]            last_q;
    logic                            served_q;
    logic                            ack_q;
    logic                            drop_q, drop_d;
    logic                            in_pkt_q;
    logic                            perr_q;
    logic [NUM_SLOTS-1:0][CNT_W-1:0] hit_cnt_q;

    logic                            sel_load;
    logic                            abort;
    logic                            hit;
    logic                            commit_now;
    logic [SLOT_BITS-1:0]            sel_c;
    int unsigned                     search_start;

    // First enabled slot at or after 'start', wrapping; keeps 'last' when nothing is enabled.
    function automatic logic [SLOT_BITS-1:0] pick_slot(input logic [NUM_SLOTS-1:0] en,
                                                       input int unsigned start,
                                                       input logic [SLOT_BITS-1:0] last);
        logic [SLOT_BITS-1:0] sel;
        logic                 found;
        int unsigned          idx;
        sel   = last;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            idx = (start + k) % NUM_SLOTS;
            if (!found && en[SLOT_BITS'(idx)]) begin
                sel   = SLOT_BITS'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        sel_load   = 1'b0;
        abort      = 1'b0;
        hit        = 1'b0;
        commit_now = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pkt_start) begin
                    state_d  = ST_IN_PKT;
                    sel_load = 1'b1;
                end else if (commit_req) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_IN_PKT: begin
                if (pkt_start) begin
                    sel_load = 1'b1;
                    abort    = 1'b1;
                end else if (pkt_end) begin
                    hit     = (|en_q) & match_in;
                    state_d = commit_req ? ST_COMMIT : ST_IDLE;
                end
            end
            ST_COMMIT: begin
                commit_now = 1'b1;
                if (pkt_start) begin
                    state_d  = ST_IN_PKT;
                    sel_load = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A packet starting in the commit cycle is scheduled from the bank being committed.
        en_d         = commit_now ? cfg_en_mask : en_q;
        // Until the first packet is served the search begins at slot 0.
        search_start = served_q ? (32'(last_q) + 32'd1) : 32'd0;
        sel_c        = pick_slot(en_d, search_start, last_q);
        pattern_d    = pattern_q;
        if (sel_load) begin
            pattern_d = commit_now ? shadow_q[sel_c] : active_q[sel_c];
        end
        mrst_d = !((state_d == ST_IN_PKT) && (|en_d));
`ifdef IDS_SCHED_DROP_EN
        drop_d = hit;
`else
        drop_d = 1'b0;
`endif
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            en_q      <= '0;
            pattern_q <= '0;
            mrst_q    <= 1'b1;
            slot_q    <= '0;
            last_q    <= '0;
            served_q  <= 1'b0;
            ack_q     <= 1'b0;
            drop_q    <= 1'b0;
            in_pkt_q  <= 1'b0;
            perr_q    <= 1'b0;
            hit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            if (cfg_wr) begin
                shadow_q[cfg_slot] <= cfg_pattern;
            end
            if (commit_now) begin
                for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            en_q      <= en_d;
            pattern_q <= pattern_d;
            mrst_q    <= mrst_d;
            if (sel_load) begin
                slot_q   <= sel_c;
                last_q   <= sel_c;
                served_q <= 1'b1;
            end
            ack_q    <= (state_d == ST_COMMIT);
            drop_q   <= drop_d;
            in_pkt_q <= (state_d == ST_IN_PKT);
            if (clear_cnt) begin
                perr_q    <= 1'b0;
                hit_cnt_q <= '0;
            end else begin
                if (abort) begin
                    perr_q <= 1'b1;
                end
                if (hit && (hit_cnt_q[slot_q] != {CNT_W{1'b1}})) begin
                    hit_cnt_q[slot_q] <= hit_cnt_q[slot_q] + CNT_W'(1);
                end
            end
        end
    end

    assign commit_ack  = ack_q;
    assign pattern_out = pattern_q;
    assign matcher_rst = mrst_q;
    assign active_slot = slot_q;
    assign drop_out    = drop_q;
    assign in_pkt      = in_pkt_q;
    assign proto_err   = perr_q;
    assign hit_cnt     = hit_cnt_q;

endmodule
